// File: rtl/dataflow_actor_scheduler_if.sv
// Scheduler bus: run control, actor enable/fc inputs,
// invoke pulses and run status.
interface dataflow_actor_scheduler_if #(
  parameter int num_actors = 4,
  parameter int cnt_width  = 16
);
  localparam int idx_w = $clog2(num_actors);

  logic                  start;
  logic [num_actors-1:0] enable;
  logic [num_actors-1:0] fc;
  logic [num_actors-1:0] invoke;
  logic [idx_w-1:0]      current;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [cnt_width-1:0]  firing_count;

  modport master (
    output start,
    output enable,
    output fc,
    input  invoke,
    input  current,
    input  busy,
    input  done,
    input  error,
    input  firing_count
  );

  modport slave (
    input  start,
    input  enable,
    input  fc,
    output invoke,
    output current,
    output busy,
    output done,
    output error,
    output firing_count
  );
endinterface

// File: rtl/dataflow_actor_scheduler.sv
// Round-robin enable/invoke scheduler for a group of
// dataflow actors; one firing in flight at a time.
module dataflow_actor_scheduler #(
  parameter int num_actors = 4,
  parameter int cnt_width  = 16,
  parameter int timeout    = 1024
) (
  input logic clk,
  input logic rst,
  dataflow_actor_scheduler_if.slave bus
);
  localparam int idx_w  = $clog2(num_actors);
  localparam int miss_w = $clog2(num_actors + 1);
  localparam int wd_w   = (timeout > 1) ? $clog2(timeout) : 1;
  localparam int wd_lim = (timeout > 0) ? timeout - 1 : 0;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] FIRE  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [idx_w-1:0]  last_idx  = idx_w'(num_actors - 1);
  localparam logic [miss_w-1:0] full_miss = miss_w'(num_actors);
  localparam logic [wd_w-1:0]   wd_last   = wd_w'(wd_lim);
  localparam logic              wd_on     = (timeout > 0);

  logic [2:0]            state, state_d;
  logic [idx_w-1:0]      current, current_d, cur_inc;
  logic [miss_w-1:0]     miss, miss_d, miss_inc;
  logic [wd_w-1:0]       wd, wd_d;
  logic [cnt_width-1:0]  count, count_d;
  logic                  error, error_d;
  logic [num_actors-1:0] invoke, invoke_d;
  logic                  busy, busy_d;
  logic                  done, done_d;

  assign cur_inc  = (current == last_idx) ? '0
                  : current + idx_w'(1);
  assign miss_inc = miss + miss_w'(1);

  // Next-state and next-output decode for the scheduler FSM.
  always_comb begin
    state_d   = state;
    current_d = current;
    miss_d    = miss;
    wd_d      = wd;
    count_d   = count;
    error_d   = error;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_d   = CHECK;
          current_d = '0;
          miss_d    = '0;
          count_d   = '0;
          error_d   = 1'b0;
        end
      end
      CHECK: begin
        if (bus.enable[current]) begin
          state_d = FIRE;
        end else begin
          current_d = cur_inc;
          miss_d    = miss_inc;
          if (miss_inc == full_miss) state_d = DONE;
        end
      end
      FIRE: begin
        state_d = WAIT;
        miss_d  = '0;
        wd_d    = '0;
      end
      WAIT: begin
        if (bus.fc[current]) begin
          state_d   = CHECK;
          current_d = cur_inc;
          if (count != '1) count_d = count + cnt_width'(1);
        end else if (wd_on && wd == wd_last) begin
          state_d = DONE;
          error_d = 1'b1;
        end else if (wd_on) begin
          wd_d = wd + wd_w'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    invoke_d = '0;
    if (state_d == FIRE)
      invoke_d = {{(num_actors-1){1'b0}}, 1'b1} << current_d;
    busy_d = (state_d == CHECK) || (state_d == FIRE)
          || (state_d == WAIT);
    done_d = (state_d == DONE);
  end

  // Register state and all outputs; reset abandons any firing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      current <= '0;
      miss    <= '0;
      wd      <= '0;
      count   <= '0;
      error   <= 1'b0;
      invoke  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      current <= current_d;
      miss    <= miss_d;
      wd      <= wd_d;
      count   <= count_d;
      error   <= error_d;
      invoke  <= invoke_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign bus.invoke       = invoke;
  assign bus.current      = current;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.error        = error;
  assign bus.firing_count = count;
endmodule

// File: tb/tb_dataflow_actor_scheduler.sv
// Directed bench for dataflow_actor_scheduler:
// 4 actors, 16-bit counter, 8-cycle watchdog.
module tb_dataflow_actor_scheduler;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  dataflow_actor_scheduler_if #(
    .num_actors(4),
    .cnt_width(16)
  ) bus ();

  dataflow_actor_scheduler #(
    .num_actors(4),
    .cnt_width(16),
    .timeout(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.enable = 4'b0;
    bus.fc = 4'b0;
    tick();
    tick();
    tests_run++;
    if ({bus.invoke, bus.current, bus.busy, bus.done,
         bus.error, bus.firing_count} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got inv=%b cur=%0d busy=%b done=%b err=%b cnt=%0d want all 0",
        bus.invoke, bus.current, bus.busy, bus.done,
        bus.error, bus.firing_count);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0",
        bus.busy, bus.done);
    end
  endtask

  task automatic test_idle_round;
    bus.enable = 4'b0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (bus.busy !== 1'b1 || bus.current !== 2'(i)
          || bus.invoke !== 4'b0) begin
        tests_failed++;
        $display("FAIL idle_check%0d got busy=%b cur=%0d inv=%b want 1 %0d 0000",
          i, bus.busy, bus.current, bus.invoke, i);
      end
      tick();
    end
    tests_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0
        || bus.firing_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL idle_done got done=%b busy=%b cnt=%0d want 1 0 0",
        bus.done, bus.busy, bus.firing_count);
    end
    tick();
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_done_pulse got %b want 0", bus.done);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_inv;
    bus.enable = 4'b1111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    for (int n = 0; n < 8; n++) begin
      exp_inv = 4'b0001 << (n % 4);
      tests_run++;
      if (bus.invoke !== exp_inv || bus.current !== 2'(n % 4)) begin
        tests_failed++;
        $display("FAIL rr_invoke%0d got inv=%b cur=%0d want %b %0d",
          n, bus.invoke, bus.current, exp_inv, n % 4);
      end
      tick();
      tests_run++;
      if (bus.invoke !== 4'b0 || bus.busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_wait%0d got inv=%b busy=%b want 0000 1",
          n, bus.invoke, bus.busy);
      end
      tick();
      bus.fc = exp_inv;
      if (n == 7) bus.enable = 4'b0000;
      tick();
      bus.fc = 4'b0;
      tests_run++;
      if (bus.firing_count !== 16'(n + 1)
          || bus.current !== 2'((n + 1) % 4)) begin
        tests_failed++;
        $display("FAIL rr_count%0d got cnt=%0d cur=%0d want %0d %0d",
          n, bus.firing_count, bus.current, n + 1, (n + 1) % 4);
      end
      tick();
    end
    repeat (3) tick();
    tests_run++;
    if (bus.done !== 1'b1 || bus.firing_count !== 16'd8
        || bus.current !== 2'd0) begin
      tests_failed++;
      $display("FAIL rr_done got done=%b cnt=%0d cur=%0d want 1 8 0",
        bus.done, bus.firing_count, bus.current);
    end
    tick();
  endtask

  task automatic test_single_actor;
    bus.enable = 4'b0100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus.current !== 2'(i) || bus.invoke !== 4'b0) begin
        tests_failed++;
        $display("FAIL single_pre%0d got cur=%0d inv=%b want %0d 0000",
          i, bus.current, bus.invoke, i);
      end
      tick();
    end
    for (int rep = 0; rep < 3; rep++) begin
      tests_run++;
      if (bus.invoke !== 4'b0100 || bus.current !== 2'd2) begin
        tests_failed++;
        $display("FAIL single_invoke%0d got inv=%b cur=%0d want 0100 2",
          rep, bus.invoke, bus.current);
      end
      tick();
      bus.fc = 4'b0100;
      if (rep == 2) bus.enable = 4'b0000;
      tick();
      bus.fc = 4'b0;
      for (int j = 0; j < 4; j++) begin
        tests_run++;
        if (bus.invoke !== 4'b0 || bus.busy !== 1'b1
            || bus.current !== 2'((3 + j) % 4)
            || bus.firing_count !== 16'(rep + 1)) begin
          tests_failed++;
          $display("FAIL single_skip%0d_%0d got inv=%b busy=%b cur=%0d cnt=%0d want 0000 1 %0d %0d",
            rep, j, bus.invoke, bus.busy, bus.current,
            bus.firing_count, (3 + j) % 4, rep + 1);
        end
        tick();
      end
    end
    tests_run++;
    if (bus.done !== 1'b1 || bus.current !== 2'd3
        || bus.firing_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL single_done got done=%b cur=%0d cnt=%0d want 1 3 3",
        bus.done, bus.current, bus.firing_count);
    end
    tick();
  endtask

  task automatic test_fc_filter;
    logic seen;
    bus.enable = 4'b0010;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus.invoke !== 4'b0010) begin
      tests_failed++;
      $display("FAIL filt_invoke got %b want 0010", bus.invoke);
    end
    bus.fc = 4'b0010;
    tick();
    bus.fc = 4'b0101;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.current !== 2'd1
        || bus.firing_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL filt_fire_fc got busy=%b cur=%0d cnt=%0d want 1 1 0",
        bus.busy, bus.current, bus.firing_count);
    end
    tick();
    tick();
    tests_run++;
    if (bus.busy !== 1'b1 || bus.current !== 2'd1
        || bus.firing_count !== 16'd0 || bus.invoke !== 4'b0) begin
      tests_failed++;
      $display("FAIL filt_other_fc got busy=%b cur=%0d cnt=%0d inv=%b want 1 1 0 0000",
        bus.busy, bus.current, bus.firing_count, bus.invoke);
    end
    bus.fc = 4'b0010;
    bus.enable = 4'b0100;
    tick();
    bus.fc = 4'b0;
    tests_run++;
    if (bus.current !== 2'd2 || bus.firing_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL filt_advance got cur=%0d cnt=%0d want 2 1",
        bus.current, bus.firing_count);
    end
    tick();
    tests_run++;
    if (bus.invoke !== 4'b0100) begin
      tests_failed++;
      $display("FAIL filt_next_invoke got %b want 0100", bus.invoke);
    end
    tick();
    bus.fc = 4'b0100;
    bus.enable = 4'b0000;
    tick();
    bus.fc = 4'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else tick();
    end
    tests_run++;
    if (seen !== 1'b1 || bus.firing_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL filt_done got seen=%b cnt=%0d want 1 2",
        seen, bus.firing_count);
    end
    tick();
  endtask

  task automatic test_timeout;
    bus.enable = 4'b0001;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tests_run++;
    if (bus.invoke !== 4'b0001) begin
      tests_failed++;
      $display("FAIL to_invoke got %b want 0001", bus.invoke);
    end
    bus.enable = 4'b0000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      tests_run++;
      if (bus.busy !== 1'b1 || bus.error !== 1'b0
          || bus.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL to_wait%0d got busy=%b err=%b done=%b want 1 0 0",
          i, bus.busy, bus.error, bus.done);
      end
    end
    tick();
    tests_run++;
    if (bus.done !== 1'b1 || bus.error !== 1'b1
        || bus.busy !== 1'b0 || bus.firing_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL to_expire got done=%b err=%b busy=%b cnt=%0d want 1 1 0 0",
        bus.done, bus.error, bus.busy, bus.firing_count);
    end
    tick();
    repeat (3) tick();
    tests_run++;
    if (bus.error !== 1'b1 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_sticky got err=%b done=%b want 1 0",
        bus.error, bus.done);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests_run++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_clear got err=%b busy=%b want 0 1",
        bus.error, bus.busy);
    end
    repeat (4) tick();
    tests_run++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_rerun_done got done=%b err=%b want 1 0",
        bus.done, bus.error);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    logic seen;
    bus.enable = 4'b1111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.fc = 4'b0001;
    tick();
    bus.fc = 4'b0;
    tick();
    tick();
    tests_run++;
    if (bus.busy !== 1'b1 || bus.current !== 2'd1
        || bus.firing_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL rm_pre got busy=%b cur=%0d cnt=%0d want 1 1 1",
        bus.busy, bus.current, bus.firing_count);
    end
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.invoke, bus.current, bus.busy, bus.done,
         bus.error, bus.firing_count} !== 25'd0) begin
      tests_failed++;
      $display("FAIL rm_async got inv=%b cur=%0d busy=%b done=%b err=%b cnt=%0d want all 0",
        bus.invoke, bus.current, bus.busy, bus.done,
        bus.error, bus.firing_count);
    end
    tick();
    rst = 1'b1;
    bus.enable = 4'b0010;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests_run++;
    if (bus.current !== 2'd0 || bus.firing_count !== 16'd0
        || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rm_restart got cur=%0d cnt=%0d busy=%b want 0 0 1",
        bus.current, bus.firing_count, bus.busy);
    end
    tick();
    tick();
    tests_run++;
    if (bus.invoke !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rm_invoke got %b want 0010", bus.invoke);
    end
    tick();
    bus.fc = 4'b0010;
    bus.enable = 4'b0000;
    tick();
    bus.fc = 4'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else tick();
    end
    tests_run++;
    if (seen !== 1'b1 || bus.firing_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL rm_done got seen=%b cnt=%0d want 1 1",
        seen, bus.firing_count);
    end
    tick();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_idle_round();
    test_round_robin();
    test_single_actor();
    test_fc_filter();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed",
      tests_run, tests_failed);
    $finish;
  end
endmodule
